mem_access_unit: RTL and testbench

- Parametrised memory stage for the pipelined MIPS core.
- Drives the data-memory request interface (dmemREN/dmemWEN/dhit), sign- or zero-extends sub-word loads, and performs sub-word stores by read-modify-write.
- Flags misaligned accesses, keeps saturating load/store/stall counters, and registers the MEM/WB outputs with flush.
- Sits between the EX/MEM latch and writeback.

---
 rtl/mem_access_unit.sv | 201 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory stage: issues dmem requests, extends sub-word loads, read-modify-writes sub-word stores.
// Phases: FIRST = load / full-width store / RMW read;  MERGE = RMW write of the merged word.
module mem_access_unit #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              in_valid,
   input  logic              in_dren,
   input  logic              in_dwen,
   input  logic [1:0]        in_size,
   input  logic              in_signed,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_store,
   input  logic [DATA_W-1:0] in_alu,
   input  logic [REG_W-1:0]  in_wreg,
   input  logic              in_regwen,
   input  logic              in_halt,
   input  logic              flush,
   input  logic              dhit,
   input  logic [DATA_W-1:0] dmemload,
   output logic              dmemREN,
   output logic              dmemWEN,
   output logic [ADDR_W-1:0] dmemaddr,
   output logic [DATA_W-1:0] dmemstore,
   output logic              stall,
   output logic              misalign,
   output logic              wb_valid,
   output logic [DATA_W-1:0] wb_data,
   output logic [REG_W-1:0]  wb_wreg,
   output logic              wb_regwen,
   output logic              wb_halt,
   output logic [CNT_W-1:0]  load_cnt,
   output logic [CNT_W-1:0]  store_cnt,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int L  = DATA_W / 8;
   localparam int OB = $clog2(L);
   localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(L - 1);

   typedef enum logic {FIRST, MERGE} phase_t;

   phase_t            phase, phase_nxt;
   logic [OB-1:0]     off;
   logic [OB+2:0]     off_bits;
   logic              mis, is_mem, mis_op, memop, full, done;
   logic [7:0]        sh_amt;
   logic [DATA_W-1:0] load_shift, load_val;
   logic [DATA_W-1:0] lane_mask, store_pos, merged;
   logic [DATA_W-1:0] merge_q, merge_nxt;

   assign off      = in_addr[OB-1:0];
   assign off_bits = {off, 3'b000};
   assign dmemaddr = in_addr & ~LANE_MASK;

   always_comb begin
      case (in_size)
         2'd0:    mis = 1'b0;
         2'd1:    mis = in_addr[0];
         2'd2:    mis = |in_addr[1:0];
         default: mis = (DATA_W == 32) || (|in_addr[2:0]);
      endcase
   end

   assign is_mem = in_valid & (in_dren | in_dwen);
   assign mis_op = is_mem & mis;
   assign memop  = is_mem & ~mis;
   assign full   = ((4'd1 << in_size) == 4'(L));

   // Right shift that moves an access of this size from the top of the word to bit 0.
   always_comb begin
      case (in_size)
         2'd0:    sh_amt = 8'(DATA_W - 8);
         2'd1:    sh_amt = 8'(DATA_W - 16);
         2'd2:    sh_amt = 8'(DATA_W - 32);
         default: sh_amt = 8'd0;
      endcase
   end

   // Big-endian lanes: shifting left by the offset puts the addressed bytes at the top.
   assign load_shift = dmemload << off_bits;

   always_comb begin
      if (in_signed) begin
         load_val = $signed(load_shift) >>> sh_amt;
      end else begin
         load_val = load_shift >> sh_amt;
      end
   end

   assign store_pos = (in_store << sh_amt) >> off_bits;
   assign lane_mask = ({DATA_W{1'b1}} << sh_amt) >> off_bits;
   assign merged    = (dmemload & ~lane_mask) | (store_pos & lane_mask);

   always_comb begin
      phase_nxt = phase;
      merge_nxt = merge_q;
      dmemREN   = 1'b0;
      dmemWEN   = 1'b0;
      dmemstore = '0;
      done      = 1'b0;
      if (RST || flush || !memop) begin
         phase_nxt = FIRST;
      end else begin
         case (phase)
            FIRST: begin
               if (in_dren) begin
                  dmemREN = 1'b1;
                  done    = dhit;
               end else if (full) begin
                  dmemWEN   = 1'b1;
                  dmemstore = in_store;
                  done      = dhit;
               end else begin
                  dmemREN = 1'b1;
                  if (dhit) begin
                     merge_nxt = merged;
                     phase_nxt = MERGE;
                  end
               end
            end
            MERGE: begin
               dmemWEN   = 1'b1;
               dmemstore = merge_q;
               done      = dhit;
               if (dhit) begin
                  phase_nxt = FIRST;
               end
            end
            default: phase_nxt = FIRST;
         endcase
      end
   end

   assign stall = memop & ~done & ~flush;

   always_ff @(posedge CLK) begin
      if (RST) begin
         phase   <= FIRST;
         merge_q <= '0;
      end else begin
         phase   <= phase_nxt;
         merge_q <= merge_nxt;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wb_valid  <= 1'b0;
         wb_data   <= '0;
         wb_wreg   <= '0;
         wb_regwen <= 1'b0;
         wb_halt   <= 1'b0;
         misalign  <= 1'b0;
      end else begin
         misalign <= mis_op & ~flush;
         if (flush) begin
            wb_valid  <= 1'b0;
            wb_regwen <= 1'b0;
         end else if (stall) begin
            wb_valid <= 1'b0;
         end else begin
            wb_valid  <= in_valid;
            wb_wreg   <= in_wreg;
            wb_halt   <= in_halt;
            wb_regwen <= in_regwen & ~mis_op;
            if (mis_op) begin
               wb_data <= '0;
            end else if (is_mem && in_dren) begin
               wb_data <= load_val;
            end else begin
               wb_data <= in_alu;
            end
         end
      end
   end

   // Counters saturate at all-ones.
   always_ff @(posedge CLK) begin
      if (RST) begin
         load_cnt  <= '0;
         store_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (done && in_dren && load_cnt != '1) begin
            load_cnt <= load_cnt + CNT_W'(1);
         end
         if (done && !in_dren && store_cnt != '1) begin
            store_cnt <= store_cnt + CNT_W'(1);
         end
         if (stall && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a 32-bit instance and a 64-bit instance with 4-bit counters.
module tb_mem_access_unit;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;
   logic RST;

   logic        a_valid, a_dren, a_dwen, a_signed, a_regwen, a_halt, a_flush, a_dhit;
   logic [1:0]  a_size;
   logic [31:0] a_addr, a_store, a_alu, a_load;
   logic [4:0]  a_wreg;
   logic        a_ren, a_wen, a_stall, a_mis, a_wbv, a_wbregwen, a_wbhalt;
   logic [31:0] a_maddr, a_mstore, a_wbdata;
   logic [4:0]  a_wbwreg;
   logic [15:0] a_lcnt, a_scnt, a_tcnt;

   logic        b_valid, b_dren, b_dwen, b_signed, b_regwen, b_halt, b_flush, b_dhit;
   logic [1:0]  b_size;
   logic [31:0] b_addr, b_maddr;
   logic [63:0] b_store, b_alu, b_load;
   logic [4:0]  b_wreg;
   logic        b_ren, b_wen, b_stall, b_mis, b_wbv, b_wbregwen, b_wbhalt;
   logic [63:0] b_mstore, b_wbdata;
   logic [4:0]  b_wbwreg;
   logic [3:0]  b_lcnt, b_scnt, b_tcnt;

   mem_access_unit u_a (
      .CLK(CLK), .RST(RST), .in_valid(a_valid), .in_dren(a_dren), .in_dwen(a_dwen),
      .in_size(a_size), .in_signed(a_signed), .in_addr(a_addr), .in_store(a_store),
      .in_alu(a_alu), .in_wreg(a_wreg), .in_regwen(a_regwen), .in_halt(a_halt),
      .flush(a_flush), .dhit(a_dhit), .dmemload(a_load), .dmemREN(a_ren), .dmemWEN(a_wen),
      .dmemaddr(a_maddr), .dmemstore(a_mstore), .stall(a_stall), .misalign(a_mis),
      .wb_valid(a_wbv), .wb_data(a_wbdata), .wb_wreg(a_wbwreg), .wb_regwen(a_wbregwen),
      .wb_halt(a_wbhalt), .load_cnt(a_lcnt), .store_cnt(a_scnt), .stall_cnt(a_tcnt)
   );

   mem_access_unit #(.DATA_W(64), .CNT_W(4)) u_b (
      .CLK(CLK), .RST(RST), .in_valid(b_valid), .in_dren(b_dren), .in_dwen(b_dwen),
      .in_size(b_size), .in_signed(b_signed), .in_addr(b_addr), .in_store(b_store),
      .in_alu(b_alu), .in_wreg(b_wreg), .in_regwen(b_regwen), .in_halt(b_halt),
      .flush(b_flush), .dhit(b_dhit), .dmemload(b_load), .dmemREN(b_ren), .dmemWEN(b_wen),
      .dmemaddr(b_maddr), .dmemstore(b_mstore), .stall(b_stall), .misalign(b_mis),
      .wb_valid(b_wbv), .wb_data(b_wbdata), .wb_wreg(b_wbwreg), .wb_regwen(b_wbregwen),
      .wb_halt(b_wbhalt), .load_cnt(b_lcnt), .store_cnt(b_scnt), .stall_cnt(b_tcnt)
   );

   typedef struct {
      logic [63:0] data;
      logic [4:0]  wreg;
      logic        regwen;
      logic        halt;
   } wb_t;

   wb_t qa[$];
   wb_t qb[$];
   int  n_chk  = 0;
   int  n_pass = 0;
   int  n_fail = 0;
   int  n_stall;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic wb_t mk(input logic [63:0] d, input logic [4:0] w, input logic r, input logic h);
      wb_t e;
      e.data = d; e.wreg = w; e.regwen = r; e.halt = h;
      return e;
   endfunction

   // Advance one clock; any writeback that appears is matched against the scoreboard.
   task automatic tick();
      wb_t e;
      @(posedge CLK);
      #1;
      if (a_wbv === 1'b1) begin
         if (qa.size() == 0) chk("a_unexpected_wb", a_wbv, 1'b0);
         else begin
            e = qa.pop_front();
            chk("a_wb_data", a_wbdata, e.data);
            chk("a_wb_wreg", a_wbwreg, e.wreg);
            chk("a_wb_regwen", a_wbregwen, e.regwen);
            chk("a_wb_halt", a_wbhalt, e.halt);
         end
      end
      if (b_wbv === 1'b1) begin
         if (qb.size() == 0) chk("b_unexpected_wb", b_wbv, 1'b0);
         else begin
            e = qb.pop_front();
            chk("b_wb_data", b_wbdata, e.data);
            chk("b_wb_wreg", b_wbwreg, e.wreg);
            chk("b_wb_regwen", b_wbregwen, e.regwen);
         end
      end
   endtask

   task automatic a_idle();
      a_valid = 0; a_dren = 0; a_dwen = 0; a_size = 0; a_signed = 0; a_regwen = 0;
      a_halt = 0; a_flush = 0; a_dhit = 0; a_addr = 0; a_store = 0; a_alu = 0; a_wreg = 0;
   endtask

   task automatic b_idle();
      b_valid = 0; b_dren = 0; b_dwen = 0; b_size = 0; b_signed = 0; b_regwen = 0;
      b_halt = 0; b_flush = 0; b_dhit = 0; b_addr = 0; b_store = 0; b_alu = 0; b_wreg = 0;
   endtask

   task automatic a_set(input logic dren, input logic dwen, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] store);
      a_valid = 1; a_dren = dren; a_dwen = dwen; a_size = size; a_signed = sgn;
      a_addr = addr; a_store = store; a_flush = 0;
   endtask

   initial begin
      RST = 1; a_idle(); b_idle(); a_load = 0; b_load = 0;
      tick(); tick();
      @(negedge CLK);
      chk("rst_ren", a_ren, 0);
      chk("rst_wbv", a_wbv, 0);
      chk("rst_lcnt", a_lcnt, 0);
      chk("rst_tcnt", a_tcnt, 0);
      tick();
      RST = 0;

      // word load, dhit after three waiting cycles
      a_set(1, 0, 2'd2, 0, 32'h104, 0); a_wreg = 5'd3; a_regwen = 1;
      qa.push_back(mk(64'hDEADBEEF, 5'd3, 1, 0));
      n_stall = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("lw_ren", a_ren, 1);
         chk("lw_addr", a_maddr, 32'h104);
         if (a_stall) n_stall++;
         tick();
      end
      a_dhit = 1; a_load = 32'hDEADBEEF;
      @(negedge CLK);
      chk("lw_stall_done", a_stall, 0);
      tick();
      chk("lw_stall_cycles", n_stall, 3);
      chk("lw_load_cnt", a_lcnt, 1);
      chk("lw_stall_cnt", a_tcnt, 3);

      // sub-word loads with immediate dhit
      a_set(1, 0, 2'd0, 1, 32'h103, 0); a_load = 32'h112233F0; a_wreg = 5'd4;
      qa.push_back(mk(64'hFFFFFFF0, 5'd4, 1, 0));
      @(negedge CLK);
      chk("lb_stall", a_stall, 0);
      tick();
      a_signed = 0;
      qa.push_back(mk(64'h000000F0, 5'd4, 1, 0));
      tick();
      a_size = 2'd1; a_addr = 32'h102; a_signed = 1;
      qa.push_back(mk(64'h000033F0, 5'd4, 1, 0));
      tick();
      a_addr = 32'h100; a_load = 32'h80011234;
      qa.push_back(mk(64'hFFFF8001, 5'd4, 1, 0));
      tick();
      chk("lb_load_cnt", a_lcnt, 5);

      // sb read-modify-write
      a_set(0, 1, 2'd0, 0, 32'h101, 32'hFFFFFFAB); a_alu = 32'h55; a_wreg = 0; a_regwen = 0;
      a_load = 32'h11223344; a_dhit = 1;
      qa.push_back(mk(64'h55, 5'd0, 0, 0));
      @(negedge CLK);
      chk("sb_ren", a_ren, 1);
      chk("sb_wen0", a_wen, 0);
      chk("sb_stall", a_stall, 1);
      tick();
      @(negedge CLK);
      chk("sb_ren1", a_ren, 0);
      chk("sb_wen", a_wen, 1);
      chk("sb_store", a_mstore, 32'h11AB3344);
      chk("sb_addr", a_maddr, 32'h100);
      chk("sb_stall_done", a_stall, 0);
      tick();
      chk("sb_store_cnt", a_scnt, 1);
      chk("sb_stall_cnt", a_tcnt, 4);

      // misaligned word load and dword on a 32-bit path
      a_set(1, 0, 2'd2, 0, 32'h102, 0); a_regwen = 1; a_wreg = 5'd9; a_alu = 32'h77; a_dhit = 0;
      qa.push_back(mk(64'h0, 5'd9, 0, 0));
      @(negedge CLK);
      chk("mis_ren", a_ren, 0);
      chk("mis_stall", a_stall, 0);
      tick();
      chk("mis_flag", a_mis, 1);
      a_size = 2'd3; a_addr = 32'h100;
      qa.push_back(mk(64'h0, 5'd9, 0, 0));
      @(negedge CLK);
      chk("mis_d_ren", a_ren, 0);
      tick();
      chk("mis_d_flag", a_mis, 1);
      chk("mis_load_cnt", a_lcnt, 5);

      // ALU pass-through with halt; stray dhit must be ignored
      a_idle(); a_valid = 1; a_alu = 32'hCAFEF00D; a_wreg = 5'd7; a_regwen = 1; a_halt = 1; a_dhit = 1;
      qa.push_back(mk(64'hCAFEF00D, 5'd7, 1, 1));
      @(negedge CLK);
      chk("alu_ren", a_ren, 0);
      tick();
      chk("alu_mis_clr", a_mis, 0);
      chk("alu_lcnt", a_lcnt, 5);
      chk("alu_scnt", a_scnt, 1);
      chk("alu_tcnt", a_tcnt, 4);

      // sh flushed in MERGE, then a clean sh
      a_idle();
      a_set(0, 1, 2'd1, 0, 32'h102, 32'h0000BEEF); a_load = 32'h11223344; a_dhit = 1;
      a_alu = 32'h1234; a_wreg = 5'd6;
      @(negedge CLK);
      chk("sh_ren", a_ren, 1);
      tick();
      a_flush = 1;
      @(negedge CLK);
      chk("flush_wen", a_wen, 0);
      chk("flush_stall", a_stall, 0);
      tick();
      chk("flush_wbv", a_wbv, 0);
      chk("flush_scnt", a_scnt, 1);
      a_flush = 0; a_dhit = 0;
      @(negedge CLK);
      chk("postflush_ren", a_ren, 1);
      chk("postflush_wen", a_wen, 0);
      tick();
      a_dhit = 1;
      tick();
      qa.push_back(mk(64'h1234, 5'd6, 0, 0));
      @(negedge CLK);
      chk("sh_wen", a_wen, 1);
      chk("sh_store", a_mstore, 32'h1122BEEF);
      tick();
      chk("sh_scnt", a_scnt, 2);
      chk("sh_tcnt", a_tcnt, 7);

      // reset while in MERGE
      a_set(0, 1, 2'd0, 0, 32'h100, 32'h5A); a_load = 32'hAABBCCDD; a_dhit = 1;
      tick();
      RST = 1;
      @(negedge CLK);
      chk("rstm_wen", a_wen, 0);
      chk("rstm_ren", a_ren, 0);
      tick();
      chk("rstm_wbdata", a_wbdata, 0);
      chk("rstm_wbwreg", a_wbwreg, 0);
      chk("rstm_wbv", a_wbv, 0);
      chk("rstm_scnt", a_scnt, 0);
      chk("rstm_tcnt", a_tcnt, 0);
      chk("rstm_lcnt", a_lcnt, 0);
      RST = 0;
      a_set(1, 0, 2'd2, 0, 32'h100, 0); a_load = 32'h600DF00D; a_wreg = 5'd2; a_regwen = 1;
      qa.push_back(mk(64'h600DF00D, 5'd2, 1, 0));
      @(negedge CLK);
      chk("rstm_first_ren", a_ren, 1);
      chk("rstm_first_wen", a_wen, 0);
      tick();
      chk("rstm_lcnt1", a_lcnt, 1);
      a_idle();

      // 64-bit datapath
      b_valid = 1; b_dren = 1; b_size = 2'd3; b_addr = 32'h108; b_load = 64'h0123456789ABCDEF;
      b_dhit = 1; b_wreg = 5'd1; b_regwen = 1;
      qb.push_back(mk(64'h0123456789ABCDEF, 5'd1, 1, 0));
      @(negedge CLK);
      chk("ld64_addr", b_maddr, 32'h108);
      chk("ld64_stall", b_stall, 0);
      tick();
      b_size = 2'd2; b_addr = 32'h10C; b_signed = 1;
      qb.push_back(mk(64'hFFFFFFFF89ABCDEF, 5'd1, 1, 0));
      @(negedge CLK);
      chk("lw64_addr", b_maddr, 32'h108);
      tick();
      b_dren = 0; b_dwen = 1; b_signed = 0; b_addr = 32'h104; b_store = 64'hCAFEBABE;
      b_alu = 64'h42; b_regwen = 0;
      tick();
      qb.push_back(mk(64'h42, 5'd1, 0, 0));
      @(negedge CLK);
      chk("sw64_wen", b_wen, 1);
      chk("sw64_store", b_mstore, 64'h01234567CAFEBABE);
      tick();
      b_dwen = 0; b_dren = 1; b_size = 2'd3; b_addr = 32'h110; b_dhit = 0; b_regwen = 1;
      for (int i = 0; i < 14; i++) tick();
      chk("sat_reach", b_tcnt, 4'hF);
      tick(); tick();
      chk("sat_hold", b_tcnt, 4'hF);
      b_dhit = 1; b_load = 64'h1122334455667788;
      qb.push_back(mk(64'h1122334455667788, 5'd1, 1, 0));
      tick();
      chk("b_lcnt", b_lcnt, 3);
      chk("b_scnt", b_scnt, 1);
      b_idle();

      tick(); tick();
      chk("qa_drained", qa.size(), 0);
      chk("qb_drained", qb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
